// File: rtl/inverter_pipe_pkg.sv
// ---------------------------------------------------------------------------
// inverter_pipe_pkg
// Definitions shared by the inverter pipeline and its skid buffer:
//   - occupancy state encoding of the 2-entry skid buffer
//   - default word and counter widths
// ---------------------------------------------------------------------------
package inverter_pipe_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 16;

  // Number of words currently held by the skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_state_t;

endpackage

// File: rtl/inverter_pipe_skid_buffer.sv
// ---------------------------------------------------------------------------
// inverter_pipe_skid_buffer
// Two-entry valid/ready skid buffer with fully registered outputs. The main
// register drives the output; the skid register catches the one word that
// arrives in the cycle the sink stalls, so the source sees full throughput.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      upstream word
//   in_ready              registered: 1 when fewer than two words are held
//   out_valid/out_data    head of the buffer (main register)
//   out_ready             downstream accepts the head word
// ---------------------------------------------------------------------------
module inverter_pipe_skid_buffer
  import inverter_pipe_pkg::*;
#(
  parameter int W = DEF_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  occ_state_t   state;
  logic [W-1:0] skid_q;
  logic         accept;

  assign accept = in_valid && in_ready;

  // Occupancy FSM. in_ready stays low through reset and rises on the first
  // edge after release, because EMPTY always re-asserts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            out_data <= in_data;
          end else if (accept) begin
            // Sink stalled: park the new word behind the head
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= ST_FULL;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/inverter_pipe.sv
// ---------------------------------------------------------------------------
// inverter_pipe
// Registered, masked inverter on a valid/ready stream. Each accepted word is
// XORed with the inversion mask in force at acceptance, buffered in a
// 2-entry skid buffer and delivered in order. word_cnt counts delivered
// words and wraps silently.
//
// Optional feature macro: INVERTER_PARITY_EN
//   When defined, out_parity carries the XOR reduction of out_data; it is
//   computed at acceptance and travels through the buffer with the word.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/cfg_mask       one-cycle mask write strobe and new mask
//   mask                  current mask register
//   in_valid/in_data/in_ready     upstream stream
//   out_valid/out_data/out_ready  downstream stream
//   word_cnt              number of output handshakes (wrapping)
//   out_parity            parity of out_data (INVERTER_PARITY_EN only)
// ---------------------------------------------------------------------------
module inverter_pipe
  import inverter_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               CNT_WIDTH = DEF_CNT_WIDTH,
  parameter logic [WIDTH-1:0] MASK_RST  = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [WIDTH-1:0]     cfg_mask,
  output logic [WIDTH-1:0]     mask,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_cnt
`ifdef INVERTER_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

`ifdef INVERTER_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic [WIDTH-1:0] word;
  logic [SW-1:0]    buf_in;
  logic [SW-1:0]    buf_out;

  // The registered mask is used, so a word accepted in the cfg_we cycle
  // still sees the old mask.
  assign word = in_data ^ mask;

`ifdef INVERTER_PARITY_EN
  assign buf_in     = {^word, word};
  assign out_data   = buf_out[WIDTH-1:0];
  assign out_parity = buf_out[WIDTH];
`else
  assign buf_in   = word;
  assign out_data = buf_out;
`endif

  // Inversion mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= MASK_RST;
    end else if (cfg_we) begin
      mask <= cfg_mask;
    end
  end

  // Delivered-word counter, wraps with no flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

  inverter_pipe_skid_buffer #(
    .W(SW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (buf_in),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (buf_out),
    .out_ready(out_ready)
  );

endmodule

// File: tb/tb_inverter_pipe.sv
// ---------------------------------------------------------------------------
// tb_inverter_pipe
// Self-checking bench for inverter_pipe (WIDTH=8, CNT_WIDTH=4 so the counter
// wraps quickly). A queue-based reference holds the transformed words in
// delivery order; a compare process checks every output on each falling
// edge, and directed sections pin literal values.
// ---------------------------------------------------------------------------
module tb_inverter_pipe;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [WIDTH-1:0]     cfg_mask = '0;
  logic [WIDTH-1:0]     mask;
  logic                 in_valid = 1'b0;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready = 1'b0;
  logic [CNT_WIDTH-1:0] word_cnt;
`ifdef INVERTER_PARITY_EN
  logic                 out_parity;
`endif

  int num_checks = 0;
  int num_fails  = 0;

  // Reference state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_mask;
  int               m_cnt;
  bit               m_rdy_ok;

  inverter_pipe #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH),
    .MASK_RST (8'hFF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_mask (cfg_mask),
    .mask     (mask),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .word_cnt (word_cnt)
`ifdef INVERTER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic r, input logic we,
                               input logic [WIDTH-1:0] cm);
    in_valid = v;
    in_data  = d;
    out_ready = r;
    cfg_we   = we;
    cfg_mask = cm;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: a FIFO of at most two transformed words. A word is accepted
  // when fewer than two are held (and not in the first cycle after reset);
  // the head leaves when the sink is ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mask   = 8'hFF;
      m_cnt    = 0;
      m_rdy_ok = 1'b0;
    end else begin
      bit acc;
      acc = in_valid && m_rdy_ok && (exp_q.size() < 2);
      if (exp_q.size() > 0 && out_ready) begin
        void'(exp_q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
      end
      if (acc) exp_q.push_back(in_data ^ m_mask);
      if (cfg_we) m_mask = cfg_mask;
      m_rdy_ok = 1'b1;
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      checkOutput("in_ready", 32'(in_ready), 32'(m_rdy_ok && exp_q.size() < 2));
      checkOutput("mask", 32'(mask), 32'(m_mask));
      checkOutput("word_cnt", 32'(word_cnt), 32'(m_cnt));
      if (exp_q.size() > 0) begin
        checkOutput("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef INVERTER_PARITY_EN
        checkOutput("out_parity", 32'(out_parity), 32'(^exp_q[0]));
`endif
      end
    end
  end

  initial begin
    // Reset values
    applyStimulus(1'b1, 8'h0F, 1'b1, 1'b0, 8'h00);
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_mask", 32'(mask), 32'hFF);
    checkOutput("rst_word_cnt", 32'(word_cnt), 32'h0);
`ifdef INVERTER_PARITY_EN
    checkOutput("rst_parity", 32'(out_parity), 32'h0);
`endif
    step();
    rst_n = 1'b1;
    step();
    checkOutput("first_in_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("first_out_data", 32'(out_data), 32'hF0);
    checkOutput("first_out_valid", 32'(out_valid), 32'h1);
`ifdef INVERTER_PARITY_EN
    checkOutput("parity_F0", 32'(out_parity), 32'h0);
`endif
    step();
    checkOutput("first_word_cnt", 32'(word_cnt), 32'h1);
    in_data = 8'h0E;
    step();
    checkOutput("data_F1", 32'(out_data), 32'hF1);
`ifdef INVERTER_PARITY_EN
    checkOutput("parity_F1", 32'(out_parity), 32'h1);
`endif

    // Mask write: same-cycle word uses the old mask
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1, 8'h0F);
    step();
    checkOutput("old_mask_word", 32'(out_data), 32'h55);
    checkOutput("new_mask", 32'(mask), 32'h0F);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("new_mask_word", 32'(out_data), 32'hA5);

    // Drain and restore the classic inverter mask
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    repeat (2) step();

    // Back-pressure: 01,02,03 with the sink stalled
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
    step();
    in_data = 8'h02;
    step();
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'h0);
    checkOutput("bp_head", 32'(out_data), 32'hFE);
    in_data = 8'h03;
    repeat (2) step();
    checkOutput("bp_head_stable", 32'(out_data), 32'hFE);
    checkOutput("bp_valid_stable", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    step();
    checkOutput("bp_second", 32'(out_data), 32'hFD);
    step();
    checkOutput("bp_third", 32'(out_data), 32'hFC);
    in_valid = 1'b0;
    repeat (2) step();
    checkOutput("bp_drained", 32'(out_valid), 32'h0);

    // Full throughput: 100 back-to-back words
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 8'h00);
      step();
      if (!in_ready) checkOutput("tp_in_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Reset while FULL
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    step();
    in_data = 8'h44;
    step();
    checkOutput("pre_reset_full", 32'(in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_rst_word_cnt", 32'(word_cnt), 32'h0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("mid_rst_mask", 32'(mask), 32'hFF);
    step();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b1;

    // Counter wrap: 17 handshakes on a 4-bit counter
    in_valid = 1'b1;
    repeat (18) step();
    in_valid = 1'b0;
    repeat (3) step();
    checkOutput("cnt_wrap", 32'(word_cnt), 32'h1);

    // Randomised traffic; the source holds a word the block has not taken
    for (int i = 0; i < 600; i++) begin
      if (in_valid && !in_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cfg_we    = 1'b0;
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 15) == 0), 8'($urandom));
      end
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
